// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU's memory-mapped UART TX address and the rs232c transmitter.
// Buffers CPU stores and drains them with the TX_DATA_EN / TX_BUSY handshake.
module uart_tx_fifo #(
   parameter int unsigned                 ADDRESS_WIDTH = 16,
   parameter logic [ADDRESS_WIDTH-1:0]    TX_ADDRESS    = ADDRESS_WIDTH'(16'hFFFF),
   parameter int unsigned                 DEPTH_LOG2    = 4,
   parameter int unsigned                 ARM_TIMEOUT   = 3
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic [ADDRESS_WIDTH-1:0]  address,
   input  logic                      wren,
   input  logic [7:0]                wr_data,
   output logic                      hold,
   output logic [7:0]                tx_data,
   output logic                      tx_en,
   input  logic                      tx_busy,
   output logic [DEPTH_LOG2:0]       level,
   output logic                      overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
   localparam int unsigned ARM_W = $clog2(ARM_TIMEOUT + 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_ARM,
      S_DRAIN
   } state_t;

   state_t                 state;
   logic [7:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wptr;
   logic [DEPTH_LOG2-1:0]  rptr;
   logic [ARM_W-1:0]       arm_cnt;
   logic                   full_c;
   logic                   store_c;
   logic                   push_c;
   logic                   pop_c;

   assign full_c  = (level == LVL_W'(DEPTH));
   assign hold    = full_c;
   assign store_c = wren && (address == TX_ADDRESS);
   // A store to a full FIFO is dropped even if a pop frees a slot on the same edge
   assign push_c  = store_c && !full_c;
   assign pop_c   = (state == S_IDLE) && (level != '0);

   // Storage array; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wptr] <= wr_data;
      end
   end

   // Pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_c) wptr <= wptr + 1'b1;
         if (pop_c)  rptr <= rptr + 1'b1;
         if (store_c && full_c) overflow <= 1'b1;
         case ({push_c, pop_c})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Drain FSM: launch one byte, wait for the transmitter to take it and finish
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state   <= S_IDLE;
         tx_en   <= 1'b0;
         tx_data <= 8'h00;
         arm_cnt <= '0;
      end else begin
         tx_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop_c) begin
                  tx_data <= mem[rptr];
                  tx_en   <= 1'b1;
                  state   <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               arm_cnt <= '0;
               state   <= S_ARM;
            end
            S_ARM: begin
               // A transmitter that never raises busy still counts the byte as sent
               if (tx_busy) begin
                  state <= S_DRAIN;
               end else if (arm_cnt == ARM_W'(ARM_TIMEOUT)) begin
                  state <= S_IDLE;
               end else begin
                  arm_cnt <= arm_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (!tx_busy) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
